// File: rtl/hdc_sequencer.sv
// ---------------------------------------------------------------------------
// hdc_sequencer
//   Control FSM for one HDC ham/spam classification. On start it captures the
//   message and its length, streams the characters to the n-gram encoder over
//   a valid/ready handshake, gates accumulation, then runs the bundling
//   threshold and the ham/spam similarity compare. It reports a 2-bit result
//   together with a one-cycle done pulse.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   start               begin a classification (sampled only in IDLE)
//   msg, length         message (char 0 in the MS byte) and valid char count
//   busy, done, result  status; result 00 ham, 01 spam, 11 inconclusive
//   enc_valid/enc_char/enc_first, enc_ready   character stream to encoder
//   acc_clr, acc_en     bundling accumulator clear / accumulate enable
//   thr_start, thr_count, thr_done            majority threshold control
//   cmp_start, cmp_done, cmp_ham_dist, cmp_spam_dist   class compare
// ---------------------------------------------------------------------------
module hdc_sequencer #(
    parameter int MESSAGE_LENGTH = 200,
    parameter int CHAR_LENGTH    = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int NGRAM          = 3,
    parameter int DIST_W         = 14
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
    input  logic [LEN_WIDTH-1:0]                  length,
    output logic                                  busy,
    output logic                                  done,
    output logic [1:0]                            result,
    output logic                                  enc_valid,
    output logic [CHAR_LENGTH-1:0]                enc_char,
    output logic                                  enc_first,
    input  logic                                  enc_ready,
    output logic                                  acc_clr,
    output logic                                  acc_en,
    output logic                                  thr_start,
    output logic [LEN_WIDTH-1:0]                  thr_count,
    input  logic                                  thr_done,
    output logic                                  cmp_start,
    input  logic                                  cmp_done,
    input  logic [DIST_W-1:0]                     cmp_ham_dist,
    input  logic [DIST_W-1:0]                     cmp_spam_dist
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_BIN, S_CMP, S_DONE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MESSAGE_LENGTH);
    localparam logic [LEN_WIDTH-1:0] NG      = LEN_WIDTH'(NGRAM);
    localparam logic [LEN_WIDTH-1:0] NG_M1   = LEN_WIDTH'(NGRAM - 1);

    state_t                 state, next_state;
    logic                   entry_p0;     // first cycle spent in the current state
    logic [LEN_WIDTH-1:0]   idx_p0;
    logic [LEN_WIDTH-1:0]   eff_len_p0;
    logic [CHAR_LENGTH-1:0] msg_p0 [MESSAGE_LENGTH];
    logic [LEN_WIDTH-1:0]   len_sat;
    logic                   capture;
    logic                   beat;
    logic                   last_beat;

    // Clamp the requested length to the message capacity.
    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // Number of complete n-grams in a message of len characters.
    function automatic logic [LEN_WIDTH-1:0] ngram_count(input logic [LEN_WIDTH-1:0] len);
        return (len >= NG) ? (len - NG_M1) : '0;
    endfunction

    function automatic logic [1:0] classify(input logic [DIST_W-1:0] ham,
                                            input logic [DIST_W-1:0] spam);
        if (ham < spam)
            return 2'b00;
        else if (spam < ham)
            return 2'b01;
        else
            return 2'b11;
    endfunction

    assign len_sat   = sat_len(length);
    assign capture   = (state == S_IDLE) && start;
    assign beat      = (state == S_FEED) && enc_ready;
    assign last_beat = beat && (idx_p0 == eff_len_p0 - LEN_WIDTH'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            entry_p0 <= 1'b0;
        end else begin
            state    <= next_state;
            entry_p0 <= (next_state != state);
        end
    end

    // Next-state logic; completion strobes are only honoured after the
    // corresponding start pulse has been issued.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_CLEAR;
            S_CLEAR: next_state = (eff_len_p0 < NG) ? S_DONE : S_FEED;
            S_FEED:  if (last_beat) next_state = S_BIN;
            S_BIN:   if (thr_done && !entry_p0) next_state = S_CMP;
            S_CMP:   if (cmp_done && !entry_p0) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Capture stage: message characters and clamped length, data only
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < MESSAGE_LENGTH; i++)
                msg_p0[i] <= msg[(MESSAGE_LENGTH-1-i)*CHAR_LENGTH +: CHAR_LENGTH];
            eff_len_p0 <= len_sat;
        end
    end

    // Control registers: character index, n-gram count, result
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_p0    <= '0;
            thr_count <= '0;
            result    <= 2'b11;
        end else begin
            if (capture)
                thr_count <= ngram_count(len_sat);
            if (state == S_CLEAR) begin
                idx_p0 <= '0;
                if (eff_len_p0 < NG)
                    result <= 2'b11;
            end else if (beat) begin
                idx_p0 <= idx_p0 + LEN_WIDTH'(1);
            end
            if ((state == S_CMP) && cmp_done && !entry_p0)
                result <= classify(cmp_ham_dist, cmp_spam_dist);
        end
    end

    // Output decode
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        acc_clr   = (state == S_CLEAR);
        enc_valid = (state == S_FEED);
        enc_char  = enc_valid ? msg_p0[idx_p0] : '0;
        enc_first = enc_valid && (idx_p0 == '0);
        acc_en    = enc_valid && (idx_p0 >= NG_M1);
        thr_start = (state == S_BIN) && entry_p0;
        cmp_start = (state == S_CMP) && entry_p0;
    end

endmodule

// File: tb/tb_hdc_sequencer.sv
module tb_hdc_sequencer;
    localparam int ML = 200;
    localparam int CL = 8;
    localparam int LW = 8;
    localparam int NG = 3;
    localparam int DW = 14;

    logic            clk = 1'b0;
    logic            reset, start, enc_ready, thr_done, cmp_done;
    logic [CL*ML-1:0] msg;
    logic [LW-1:0]   length;
    logic            busy, done, enc_valid, enc_first, acc_clr, acc_en, thr_start, cmp_start;
    logic [1:0]      result;
    logic [CL-1:0]   enc_char;
    logic [LW-1:0]   thr_count;
    logic [DW-1:0]   cmp_ham_dist, cmp_spam_dist;

    always #5 clk = ~clk;

    hdc_sequencer #(.MESSAGE_LENGTH(ML), .CHAR_LENGTH(CL), .LEN_WIDTH(LW),
                    .NGRAM(NG), .DIST_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .msg(msg), .length(length),
        .busy(busy), .done(done), .result(result),
        .enc_valid(enc_valid), .enc_char(enc_char), .enc_first(enc_first),
        .enc_ready(enc_ready), .acc_clr(acc_clr), .acc_en(acc_en),
        .thr_start(thr_start), .thr_count(thr_count), .thr_done(thr_done),
        .cmp_start(cmp_start), .cmp_done(cmp_done),
        .cmp_ham_dist(cmp_ham_dist), .cmp_spam_dist(cmp_spam_dist));

    typedef struct { logic [CL-1:0] ch; logic first; logic acc; } beat_t;
    typedef struct { logic [1:0] res; int due; } res_t;

    beat_t         beat_q[$];
    res_t          res_q[$];
    logic [LW-1:0] thr_q[$];
    int            clr_q[$];
    int            cmp_q[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, done_count = 0, hs_count = 0;
    int ready_mode = 0;       // 0 always ready, 1 toggling, 2 random
    bit fixed_delay = 1'b1;   // thr/cmp done exactly one cycle after start
    logic [DW-1:0] ham_d, spam_d;
    int d_thr, d_cmp;
    logic prev_stall = 1'b0, prev_first = 1'b0, prev_done = 1'b0;
    logic [CL-1:0] prev_char = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what one classification must produce
    task automatic push_run(input logic [CL*ML-1:0] m, input logic [LW-1:0] len,
                            input logic [DW-1:0] h, input logic [DW-1:0] s,
                            input int start_cyc, input bit timed);
        int eff;
        beat_t b;
        res_t r;
        eff = (int'(len) > ML) ? ML : int'(len);
        clr_q.push_back(1);
        if (eff < NG) begin
            r.res = 2'b11;
            r.due = timed ? start_cyc + 2 : -1;
        end else begin
            for (int i = 0; i < eff; i++) begin
                b.ch    = m[(ML-1-i)*CL +: CL];
                b.first = (i == 0);
                b.acc   = (i >= NG - 1);
                beat_q.push_back(b);
            end
            thr_q.push_back(LW'(eff - NG + 1));
            cmp_q.push_back(1);
            r.res = (h < s) ? 2'b00 : ((s < h) ? 2'b01 : 2'b11);
            r.due = timed ? start_cyc + eff + 6 : -1;
        end
        res_q.push_back(r);
    endtask

    function automatic int exp_beats(input logic [LW-1:0] len);
        int eff;
        eff = (int'(len) > ML) ? ML : int'(len);
        return (eff < NG) ? 0 : eff;
    endfunction

    task automatic randomize_msg();
        for (int w = 0; w < CL*ML/32; w++) msg[w*32 +: 32] = $urandom();
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_count == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_seen", done_count != d0, 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_beats_left"}, beat_q.size(), 0);
        check({tag, "_thr_left"}, thr_q.size(), 0);
        check({tag, "_cmp_left"}, cmp_q.size(), 0);
        check({tag, "_clr_left"}, clr_q.size(), 0);
        check({tag, "_res_left"}, res_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_enc_valid"}, enc_valid, 0);
        check({tag, "_acc_clr"}, acc_clr, 0);
        check({tag, "_acc_en"}, acc_en, 0);
        check({tag, "_thr_start"}, thr_start, 0);
        check({tag, "_cmp_start"}, cmp_start, 0);
        check({tag, "_result"}, result, 2'b11);
        check({tag, "_thr_count"}, thr_count, 0);
    endtask

    // One complete classification; inputs are scrambled after capture.
    task automatic run(input string tag, input logic [LW-1:0] len,
                       input logic [DW-1:0] h, input logic [DW-1:0] s, input bit timed);
        int d0, hs0;
        @(posedge clk); #1;
        randomize_msg();
        length = len;
        ham_d  = h;
        spam_d = s;
        start  = 1'b1;
        d0     = done_count;
        hs0    = hs_count;
        push_run(msg, len, h, s, cyc, timed);
        @(posedge clk); #1;
        start = 1'b0;
        randomize_msg();
        length = LW'($urandom());
        wait_done(d0, 2000);
        check({tag, "_handshakes"}, hs_count - hs0, exp_beats(len));
        check_drained(tag);
    endtask

    // Encoder ready generator
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       enc_ready = 1'b1;
            1:       enc_ready = ~enc_ready;
            default: enc_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Threshold unit responder
    always begin
        @(negedge clk);
        if (thr_start) begin
            d_thr = fixed_delay ? 1 : int'($urandom_range(1, 4));
            repeat (d_thr) @(posedge clk);
            #1 thr_done = 1'b1;
            @(posedge clk);
            #1 thr_done = 1'b0;
        end
    end

    // Compare unit responder; distances are only meaningful while cmp_done
    always begin
        @(negedge clk);
        if (cmp_start) begin
            d_cmp = fixed_delay ? 1 : int'($urandom_range(1, 4));
            repeat (d_cmp) @(posedge clk);
            #1;
            cmp_done      = 1'b1;
            cmp_ham_dist  = ham_d;
            cmp_spam_dist = spam_d;
            @(posedge clk);
            #1;
            cmp_done      = 1'b0;
            cmp_ham_dist  = DW'($urandom());
            cmp_spam_dist = DW'($urandom());
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin : monitor
        automatic beat_t b;
        automatic res_t  r;
        automatic logic [LW-1:0] t;
        if (prev_stall && enc_valid) begin
            check("stall_char", enc_char, prev_char);
            check("stall_first", enc_first, prev_first);
        end
        if (acc_en && !enc_valid) check("acc_en_without_valid", acc_en, 0);
        if (enc_valid && enc_ready) begin
            hs_count <= hs_count + 1;
            if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
            else begin
                b = beat_q.pop_front();
                check("enc_char", enc_char, b.ch);
                check("enc_first", enc_first, b.first);
                check("acc_en", acc_en, b.acc);
            end
        end
        if (acc_clr) begin
            if (clr_q.size() == 0) check("unexpected_acc_clr", 1, 0);
            else void'(clr_q.pop_front());
        end
        if (thr_start) begin
            if (thr_q.size() == 0) check("unexpected_thr_start", 1, 0);
            else begin
                t = thr_q.pop_front();
                check("thr_count", thr_count, t);
            end
        end
        if (cmp_start) begin
            if (cmp_q.size() == 0) check("unexpected_cmp_start", 1, 0);
            else void'(cmp_q.pop_front());
        end
        if (done) begin
            done_count <= done_count + 1;
            check("busy_at_done", busy, 1);
            if (prev_done) check("done_pulse_width", 2, 1);
            if (res_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                r = res_q.pop_front();
                check("result", result, r.res);
                if (r.due >= 0) check("done_cycle", cyc, r.due);
            end
        end
        prev_stall <= enc_valid && !enc_ready;
        prev_char  <= enc_char;
        prev_first <= enc_first;
        prev_done  <= done;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, hs0;
        logic [LW-1:0] len;
        logic [DW-1:0] h, s;
        reset = 1'b0; start = 1'b0; msg = '0; length = '0;
        thr_done = 1'b0; cmp_done = 1'b0; enc_ready = 1'b1;
        cmp_ham_dist = '0; cmp_spam_dist = '0; ham_d = '0; spam_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic run, then stalling encoder, short message, oversize length
        ready_mode = 0; fixed_delay = 1'b1;
        run("t1", 8'd5, 14'd10, 14'd20, 1'b1);
        ready_mode = 1;
        run("t2", 8'd5, 14'd30, 14'd7, 1'b0);
        ready_mode = 0;
        run("t3", 8'd2, 14'd1, 14'd2, 1'b1);
        run("t3b", 8'd0, 14'd5, 14'd2, 1'b1);
        run("t3c", 8'd3, 14'd9, 14'd2, 1'b1);
        run("t4", 8'd255, 14'd50, 14'd50, 1'b1);

        // start re-asserted during FEED and held through DONE, dropped in IDLE
        @(posedge clk); #1;
        randomize_msg(); length = 8'd8; ham_d = 14'd3; spam_d = 14'd4;
        start = 1'b1; d0 = done_count; hs0 = hs_count;
        push_run(msg, length, ham_d, spam_d, cyc, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        wait_done(d0, 200);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t5_no_rerun_busy", busy, 0);
        end
        check("t5_handshakes", hs_count - hs0, 8);
        check_drained("t5");

        // start held into the following IDLE cycle launches exactly one more run
        @(posedge clk); #1;
        start = 1'b1; d0 = done_count;
        push_run(msg, length, ham_d, spam_d, cyc, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        wait_done(d0, 200);
        @(posedge clk); #1;
        start = 1'b1;
        push_run(msg, length, ham_d, spam_d, cyc, 1'b1);
        d0 = done_count;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, 200);
        check_drained("t5b");

        // Reset in the middle of FEED aborts the run
        @(posedge clk); #1;
        randomize_msg(); length = 8'd20; ham_d = 14'd1; spam_d = 14'd2;
        start = 1'b1;
        push_run(msg, length, ham_d, spam_d, cyc, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        beat_q.delete(); thr_q.delete(); cmp_q.delete(); clr_q.delete(); res_q.delete();
        @(negedge clk);
        check_reset_outputs("t6");
        repeat (4) begin
            @(negedge clk);
            check("t6_idle_busy", busy, 0);
        end
        run("t6_fresh", 8'd6, 14'd40, 14'd12, 1'b1);

        // Randomized runs with random ready and completion delays
        ready_mode = 2; fixed_delay = 1'b0;
        for (int k = 0; k < 25; k++) begin
            len = LW'($urandom_range(0, 255));
            h   = DW'($urandom());
            s   = ($urandom_range(0, 3) == 0) ? h : DW'($urandom());
            run("rnd", len, h, s, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
